// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the fetch PC, fills the F/D latch, and holds two bubbles per branch/JAL until execute resolves it.
// Define FETCH_PERF_EN to add the redirectCount output (count of taken redirects).
module fetch_stage #(
    parameter int               DBITS    = 32,
    parameter logic [DBITS-1:0] START_PC = 64,
    parameter logic [DBITS-1:0] NOP_INSN = 32'h3b000099
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] iMemIn,
    input  logic [DBITS-1:0] execStageImm,
    input  logic [DBITS-1:0] execStageRs1,
    input  logic             execStageCmp,
    output logic [DBITS-1:0] pc,
    output logic [DBITS-1:0] instruction
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      redirectCount
`endif
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] WAIT_D = 2'd1;
    localparam logic [1:0] WAIT_E = 2'd2;

    logic [1:0]       state;
    logic [DBITS-1:0] saved_pc4;
    logic             saved_jal;
    logic [DBITS-1:0] pc_plus4;
    logic [DBITS-1:0] redirect_pc;
    logic             is_branch;
    logic             is_jal;

    // Word immediates are scaled to bytes; the sum wraps at DBITS.
    function automatic logic [DBITS-1:0] offset_target(input logic [DBITS-1:0] base,
                                                       input logic [DBITS-1:0] imm);
        return base + (imm << 2);
    endfunction

    assign is_branch = (iMemIn[31:28] == 4'hC);
    assign is_jal    = (iMemIn[31:24] == 8'h01);
    assign pc_plus4  = pc + DBITS'(4);

    always_comb begin
        redirect_pc = saved_pc4;
        if (saved_jal) begin
            redirect_pc = offset_target(execStageRs1, execStageImm);
        end else if (execStageCmp) begin
            redirect_pc = offset_target(saved_pc4, execStageImm);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= START_PC;
            instruction <= NOP_INSN;
            state       <= RUN;
            saved_pc4   <= '0;
            saved_jal   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    instruction <= iMemIn;
                    pc          <= pc_plus4;
                    if (is_branch || is_jal) begin
                        saved_jal <= is_jal;
                        saved_pc4 <= pc_plus4;
                        state     <= WAIT_D;
                    end
                end
                WAIT_D: begin
                    instruction <= NOP_INSN;
                    state       <= WAIT_E;
                end
                WAIT_E: begin
                    instruction <= NOP_INSN;
                    pc          <= redirect_pc;
                    state       <= RUN;
                end
                default: begin
                    instruction <= NOP_INSN;
                    state       <= RUN;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            redirectCount <= 32'd0;
        end else if (state == WAIT_E && redirect_pc != saved_pc4) begin
            redirectCount <= redirectCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, JAL/BEQ loop, not-taken branch, negative offsets, reset mid-stall.
// Redirect-count checks are compiled in when FETCH_PERF_EN is defined.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h3b000099;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iMemIn;
    logic [31:0] execStageImm;
    logic [31:0] execStageRs1;
    logic        execStageCmp;
    logic [31:0] pc;
    logic [31:0] instruction;
`ifdef FETCH_PERF_EN
    logic [31:0] redirectCount;
`endif

    int tests  = 0;
    int failed = 0;
    int exp_cnt = 0;

    fetch_stage #(.DBITS(32), .START_PC(32'd64), .NOP_INSN(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .iMemIn       (iMemIn),
        .execStageImm (execStageImm),
        .execStageRs1 (execStageRs1),
        .execStageCmp (execStageCmp),
        .pc           (pc),
        .instruction  (instruction)
`ifdef FETCH_PERF_EN
        ,
        .redirectCount(redirectCount)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: a few fixed words, everything else a distinct non-control filler.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h2f000000;
            32'h44:  return 32'h01000001;
            32'h00:  return 32'hC0000f00;
            32'h0C:  return 32'h01ABCDEF;
            32'hFC:  return 32'h01000000;
            default: return 32'h13000000 | a;
        endcase
    endfunction

    assign iMemIn = imem(pc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_chk(input string tag, input logic [31:0] exp_insn, input logic [31:0] exp_pc);
        @(posedge clk);
        #1;
        chk({tag, ".insn"}, instruction, exp_insn);
        chk({tag, ".pc"}, pc, exp_pc);
    endtask

    task automatic chk_cnt(input string tag);
`ifdef FETCH_PERF_EN
        chk(tag, redirectCount, exp_cnt);
`endif
    endtask

    // One pass 0x40 -> 0x44 (JAL to 0) -> 0x0 (BEQ +15 words or fall through).
    // Misleading exec values are driven outside WAIT_E to show they are ignored.
    task automatic run_loop(input bit taken);
        execStageRs1 = 32'h1234; execStageImm = 32'd3; execStageCmp = 1'b1;
        step_chk("loop.seq", 32'h2f000000, 32'h44);
        step_chk("loop.jal", 32'h01000001, 32'h48);
        step_chk("loop.jal_wd", NOP, 32'h48);
        execStageRs1 = 32'h0; execStageImm = 32'h0; execStageCmp = 1'b1;
        step_chk("loop.jal_we", NOP, 32'h0);
        exp_cnt++;
        chk_cnt("loop.cnt_jal");
        execStageCmp = 1'b1; execStageImm = 32'd99; execStageRs1 = 32'h777;
        step_chk("loop.beq", 32'hC0000f00, 32'h4);
        step_chk("loop.beq_wd", NOP, 32'h4);
        execStageCmp = taken; execStageImm = 32'd15; execStageRs1 = 32'h999;
        step_chk("loop.beq_we", NOP, taken ? 32'h40 : 32'h4);
        if (taken) exp_cnt++;
        chk_cnt("loop.cnt_beq");
    endtask

    initial begin
        reset = 1'b1;
        execStageImm = 32'h0; execStageRs1 = 32'h0; execStageCmp = 1'b0;
        step_chk("reset", NOP, 32'h40);
        chk_cnt("reset.cnt");
        reset = 1'b0;

        run_loop(1'b1);
        run_loop(1'b1);
        run_loop(1'b1);
        run_loop(1'b0);

        // Sequential resume after the not-taken branch, then a JAL with negative offset.
        step_chk("seq4", 32'h13000004, 32'h8);
        step_chk("seq8", 32'h13000008, 32'hC);
        step_chk("jal2", 32'h01ABCDEF, 32'h10);
        step_chk("jal2_wd", NOP, 32'h10);
        execStageRs1 = 32'h100; execStageImm = 32'hFFFFFFFE; execStageCmp = 1'b0;
        step_chk("jal2_we", NOP, 32'hF8);
        exp_cnt++;
        chk_cnt("jal2.cnt");

        // JAL that lands exactly on its own pc+4 is not counted as a redirect.
        step_chk("seqF8", 32'h130000F8, 32'hFC);
        step_chk("jal3", 32'h01000000, 32'h100);
        step_chk("jal3_wd", NOP, 32'h100);
        execStageRs1 = 32'hF8; execStageImm = 32'd2; execStageCmp = 1'b1;
        step_chk("jal3_we", NOP, 32'h100);
        chk_cnt("jal3.cnt");
        step_chk("seq100", 32'h13000100, 32'h104);

        // Reset asserted while a JAL sits in WAIT_D: no redirect, back to RUN.
        reset = 1'b1;
        step_chk("rst2", NOP, 32'h40);
        reset = 1'b0;
        step_chk("rst2.seq", 32'h2f000000, 32'h44);
        step_chk("rst2.jal", 32'h01000001, 32'h48);
        execStageRs1 = 32'h200; execStageImm = 32'd4; execStageCmp = 1'b1;
        reset = 1'b1;
        step_chk("rst_wd", NOP, 32'h40);
        exp_cnt = 0;
        chk_cnt("rst_wd.cnt");
        reset = 1'b0;
        step_chk("rst_wd.run", 32'h2f000000, 32'h44);
        step_chk("rst_wd.jal", 32'h01000001, 32'h48);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
